cache_ctrl_4way: RTL and testbench
==================================

Name: cache_ctrl_4way

Overview:
Sequencing controller for a read-only, 4-way set-associative cache with one-word lines. It accepts CPU read requests, performs the tag lookup and returns hit data. On a miss it fetches the word over a request/acknowledge memory port and installs it in a victim way. The victim is chosen by the team's "any but most-recently-used" replacement policy. The controller owns the tag, valid, data and MRU state for every set.

Parameters:
ADDR_W, 8, CPU/memory address width in bits
DATA_W, 8, data word width in bits
IDX_W, 2, set index width; SETS = 2**IDX_W; TAG_W = ADDR_W-IDX_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  read request; held with cpu_addr stable until cpu_ack
cpu_addr  in  ADDR_W  read address; index = [IDX_W-1:0], tag = [ADDR_W-1:IDX_W]
cpu_ack  out  1  one-cycle response pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
cpu_hit  out  1  1 = response was a hit, 0 = served by refill; valid with cpu_ack
mem_req  out  1  refill request
mem_addr  out  ADDR_W  refill address, stable while mem_req=1
mem_ack  in  1  refill done; mem_rdata valid this cycle
mem_rdata  in  DATA_W  refill data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, all valid bits=0, MRU of every set=way 0, all outputs 0, including mem_addr and cpu_rdata. Tag and data arrays need not be cleared.
- All outputs are registered.
- States: IDLE, LOOKUP, MISS, RESP.
- IDLE: if cpu_req=1, latch cpu_addr and go to LOOKUP. Otherwise stay in IDLE.
- LOOKUP: compare the latched tag against all 4 ways of the indexed set. A way hits if its valid bit is 1 and its tag matches.
  - Hit: set MRU=hit way, load cpu_rdata from that way, set cpu_hit=1, go to RESP.
  - Miss: compute the victim, register it, drive mem_req=1 and mem_addr=latched address, go to MISS.
- Multiple matching ways cannot arise (install only on miss). If forced, the lowest-index matching way wins.
- Victim rule:
  - If any way in the set is invalid, choose the lowest-index invalid way.
  - Otherwise choose the lowest-index way that is not the MRU way (way 0, or way 1 when MRU=0).
  - The MRU way is never evicted.
- MISS: hold mem_req and mem_addr until mem_ack=1 is sampled. Wait time is unbounded; there is no timeout. On mem_ack=1:
  - write tag and mem_rdata into the victim way and set its valid bit to 1;
  - set MRU=victim;
  - set cpu_rdata=mem_rdata, cpu_hit=0, mem_req=0;
  - go to RESP.
- mem_ack while mem_req=0 is ignored.
- RESP: cpu_ack=1 for exactly one cycle, then go to IDLE. cpu_ack, cpu_hit and mem_req clear on exit.
- If cpu_req is still 1 in IDLE after an ack, it is a new request.
- Latency, with the accept edge = edge 0:
  - Hit: cpu_ack is high in the cycle after edge 2.
  - Miss: mem_req rises after edge 2; cpu_ack rises one edge after mem_ack is sampled.
- cpu_req changes outside IDLE are ignored; the address is latched only in IDLE.
- Only the indexed set's state changes per transaction. Other sets are untouched.
- Reset mid-operation (any state): next edge gives IDLE, mem_req=0, cpu_ack=0, all lines invalid. A later mem_ack is ignored.

Test Plan:
- Reset, then read 0x10 with mem_ack 3 cycles after mem_req and mem_rdata=0xA5 → mem_addr=0x10, cpu_ack with cpu_rdata=0xA5, cpu_hit=0. Re-read 0x10 → no mem_req, cpu_ack 2 edges after accept, cpu_hit=1, data 0xA5.
- Fill set 0 by missing on 0x00, 0x04, 0x08, 0x0C (data 1,2,3,4) → installed in ways 0,1,2,3 in order; MRU=3. Miss on 0x10 → way 0 evicted, so a re-read of 0x00 misses while 0x04 hits.
- Continuing from the previous scenario: hit 0x04 (MRU=way 1), then miss 0x14 → victim way 0 (holds 0x10); 0x04, 0x08 and 0x0C still hit.
- With set 0 full and MRU=way 0, miss on a new tag → way 1 is evicted, never way 0.
- Assert rst_n=0 for one edge while in MISS with mem_req=1 → mem_req=0 next cycle, busy=0. A stray mem_ack afterwards is ignored. Re-reading a previously cached address misses.
- Fill set 1 (0x01) then read set 2 (0x02) → set 1 stays valid; cpu_req toggled during MISS is ignored, and exactly one cpu_ack is issued per accepted request.

Source files
------------

// File: rtl/cache_ctrl_4way.sv
// Read-only 4-way set-associative cache controller with one-word lines and
// "any but MRU" replacement. Hit: cpu_ack two edges after accept. Miss: mem_req
// two edges after accept, cpu_ack one edge after mem_ack. No internal backpressure;
// the CPU holds cpu_req until cpu_ack and the memory port may stall indefinitely.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   cpu_req/cpu_addr      CPU read request and address (index = low IDX_W bits)
//   cpu_ack/cpu_rdata/cpu_hit  one-cycle response with data and hit flag
//   mem_req/mem_addr      refill request, held until mem_ack
//   mem_ack/mem_rdata     refill completion and data
//   busy                  high whenever the controller is not in IDLE
module cache_ctrl_4way #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SETS  = 2 ** IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAYS  = 4;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          victim_q, victim_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                cpu_hit_q, cpu_hit_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q;

  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [DATA_W-1:0]   data_q  [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [1:0]          mru_q   [SETS];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic [1:0]          hit_way;
  logic [1:0]          victim;
  logic                inv_found;
  logic                install;
  logic                mru_wr;
  logic [1:0]          mru_way;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  // Scan downwards so the lowest-index match is the last one assigned.
  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  // Victim: lowest invalid way, else lowest way that is not the MRU way.
  always_comb begin
    victim    = 2'd0;
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[idx][w]) begin
        victim    = 2'(w);
        inv_found = 1'b1;
      end
    end
    if (!inv_found) begin
      victim = (mru_q[idx] == 2'd0) ? 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    victim_d    = victim_q;
    cpu_ack_d   = 1'b0;
    cpu_hit_d   = cpu_hit_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    install     = 1'b0;
    mru_wr      = 1'b0;
    mru_way     = 2'd0;
    unique case (state_q)
      IDLE: begin
        // The ack cycle is spent here, so hit status clears on leaving it.
        cpu_hit_d = 1'b0;
        if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          mru_wr      = 1'b1;
          mru_way     = hit_way;
          cpu_rdata_d = data_q[idx][hit_way];
          cpu_hit_d   = 1'b1;
          state_d     = RESP;
        end else begin
          victim_d   = victim;
          mem_addr_d = addr_q;
          state_d    = MISS;
        end
      end
      MISS: begin
        // mem_ack only counts once mem_req is visible on the port.
        if (mem_req_q && mem_ack) begin
          install     = 1'b1;
          mru_wr      = 1'b1;
          mru_way     = victim_q;
          cpu_rdata_d = mem_rdata;
          cpu_hit_d   = 1'b0;
          mem_req_d   = 1'b0;
          state_d     = RESP;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      RESP: begin
        cpu_ack_d = 1'b1;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      victim_q    <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_hit_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        mru_q[s]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      victim_q    <= victim_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= (state_d != IDLE);
      if (install) valid_q[idx][victim_q] <= 1'b1;
      if (mru_wr)  mru_q[idx] <= mru_way;
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (rst_n && install) begin
      tag_q[idx][victim_q]  <= tag;
      data_q[idx][victim_q] <= mem_rdata;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cache_ctrl_4way.sv
// Directed bench for cache_ctrl_4way: hand-computed hit/miss/replacement
// sequences, latency, reset-in-flight and set isolation.
module tb_cache_ctrl_4way;

  logic       clk = 1'b0;
  logic       rst_n, cpu_req, cpu_ack, cpu_hit, mem_req, mem_ack, busy;
  logic [7:0] cpu_addr, cpu_rdata, mem_addr, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_ctrl_4way #(.ADDR_W(8), .DATA_W(8), .IDX_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_hit  (cpu_hit),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One CPU read. Edge 0 is the accept edge; n counts edges after it.
  // Miss: mem_ack is raised in the dly-th cycle that mem_req is high.
  task automatic do_read(input logic [7:0] addr, input bit exp_hit,
                         input logic [7:0] data, input int dly, input bit toggle);
    int n, req_edge, req_cycles, ack_edge, hold_err;
    bit seen_req, done;
    string t;
    n = 0; req_edge = -1; req_cycles = 0; ack_edge = -1; hold_err = 0;
    seen_req = 1'b0; done = 1'b0;
    t = $sformatf("rd%02h", addr);
    cpu_addr = addr;
    cpu_req  = 1'b1;
    @(posedge clk); #1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      mem_ack = 1'b0;
      if (n == 1) check({t, "_busy"}, busy, 1);
      if (mem_req) begin
        if (!seen_req) begin
          seen_req = 1'b1;
          req_edge = n;
          check({t, "_mem_addr"}, mem_addr, addr);
        end
        req_cycles++;
        if (req_cycles == dly) begin
          mem_ack   = 1'b1;
          mem_rdata = data;
        end
        if (toggle) begin
          cpu_req  = ~cpu_req;
          cpu_addr = ~addr;
        end
      end else if (seen_req && ack_edge < 0 && n < req_edge + dly) begin
        hold_err++;
      end
      if (cpu_ack) begin
        ack_edge = n;
        done     = 1'b1;
      end
    end
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    check({t, "_ack_seen"}, done, 1);
    check({t, "_hit"}, cpu_hit, exp_hit);
    check({t, "_rdata"}, cpu_rdata, data);
    check({t, "_mem_req_seen"}, seen_req, !exp_hit);
    check({t, "_mem_req_at_ack"}, mem_req, 0);
    if (exp_hit) begin
      check({t, "_ack_edge"}, ack_edge, 2);
    end else begin
      check({t, "_req_edge"}, req_edge, 2);
      check({t, "_ack_edge"}, ack_edge, 3 + dly);
      check({t, "_req_hold"}, hold_err, 0);
    end
    @(posedge clk); #1;
    check({t, "_ack_pulse"}, cpu_ack, 0);
    check({t, "_idle"}, busy, 0);
    check({t, "_hit_clr"}, cpu_hit, 0);
  endtask

  initial begin
    cpu_addr  = 8'h00;
    mem_rdata = 8'h00;
    do_reset();

    // Reset state of every output.
    check("rst_ack",   cpu_ack,   0);
    check("rst_hit",   cpu_hit,   0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_req",   mem_req,   0);
    check("rst_maddr", mem_addr,  0);
    check("rst_busy",  busy,      0);

    // Basic miss then hit.
    do_read(8'h10, 0, 8'hA5, 3, 0);
    do_read(8'h10, 1, 8'hA5, 1, 0);

    // Fill set 0 in way order, MRU ends at way 3.
    do_reset();
    do_read(8'h00, 0, 8'h01, 1, 0);
    do_read(8'h04, 0, 8'h02, 2, 0);
    do_read(8'h08, 0, 8'h03, 1, 0);
    do_read(8'h0C, 0, 8'h04, 4, 0);
    do_read(8'h10, 0, 8'h50, 1, 0);   // evicts way 0 (0x00), MRU=0
    do_read(8'h04, 1, 8'h02, 1, 0);   // MRU=1
    do_read(8'h14, 0, 8'h54, 2, 0);   // evicts way 0 (0x10), MRU=0
    do_read(8'h08, 1, 8'h03, 1, 0);
    do_read(8'h0C, 1, 8'h04, 1, 0);
    do_read(8'h04, 1, 8'h02, 1, 0);   // MRU=1
    do_read(8'h00, 0, 8'h61, 1, 0);   // evicted earlier; evicts way 0 (0x14), MRU=0
    do_read(8'h10, 0, 8'h70, 2, 0);   // MRU=0 -> way 1 (0x04) evicted, MRU=1
    do_read(8'h00, 1, 8'h61, 1, 0);   // MRU way survived
    do_read(8'h08, 1, 8'h03, 1, 0);
    do_read(8'h0C, 1, 8'h04, 1, 0);
    do_read(8'h10, 1, 8'h70, 1, 0);   // MRU=1
    do_read(8'h04, 0, 8'h44, 1, 0);   // evicts way 0 (0x00)
    do_read(8'h04, 1, 8'h44, 1, 0);

    // Reset while a refill is outstanding.
    cpu_addr = 8'h20;
    cpu_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_req) break;
    end
    check("mr_reached", mem_req, 1);
    cpu_req = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mr_req",   mem_req,   0);
    check("mr_busy",  busy,      0);
    check("mr_ack",   cpu_ack,   0);
    check("mr_maddr", mem_addr,  0);
    check("mr_rdata", cpu_rdata, 0);
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    check("stray_req",  mem_req, 0);
    check("stray_busy", busy,    0);
    check("stray_ack",  cpu_ack, 0);
    do_read(8'h08, 0, 8'h88, 2, 0);   // lines were invalidated

    // Set isolation and cpu_req toggling during a refill.
    do_read(8'h01, 0, 8'h11, 2, 0);
    do_read(8'h02, 0, 8'h22, 4, 1);
    do_read(8'h01, 1, 8'h11, 1, 0);
    do_read(8'h02, 1, 8'h22, 1, 0);
    do_read(8'h08, 1, 8'h88, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
